// File: rtl/arithmetic_left_shift_pipelined_with_overflow_if.sv
// Valid/ready bundle for the pipelined arithmetic left shifter.
// Upstream side carries operand + shift amount; downstream carries result + overflow flag.
// slave = the shifter itself; master = the block that feeds and drains it.
interface arithmetic_left_shift_pipelined_with_overflow_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shamt;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;
    logic          down_ovf;

    modport slave (
        input  up_valid, up_data, up_shamt, down_ready,
        output up_ready, down_valid, down_data, down_ovf
    );

    modport master (
        output up_valid, up_data, up_shamt, down_ready,
        input  up_ready, down_valid, down_data, down_ovf
    );
endinterface

// File: rtl/arithmetic_left_shift_pipelined_with_overflow.sv
// Purpose: signed a * 2**s as a log barrel shifter (stage k shifts by 2**k) with sticky signed-overflow detect.
// Latency: SW = $clog2(N) register stages; one item per cycle when downstream is ready.
// Backpressure: per-stage ready chain, bubbles collapse, full pipe holds SW items; ARITH_LSHIFT_SATURATE_EN saturates on overflow.
module arithmetic_left_shift_pipelined_with_overflow #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    arithmetic_left_shift_pipelined_with_overflow_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic          vld;
        logic [N-1:0]  data;
        logic [SW-1:0] shamt;
        logic          ovf;
        logic          sign;   // original a[N-1], used to pick the saturation value
    } stage_t;

    stage_t        st_in [SW];
    stage_t        st_d  [SW];
    stage_t        st_q  [SW];
    logic [SW-1:0] stage_rdy;

    // Stage inputs: stage 0 from the upstream port, stage k from stage k-1.
    always_comb begin
        st_in[0] = {bus.up_valid, bus.up_data, bus.up_shamt, 1'b0, bus.up_data[N-1]};
        for (int k = 1; k < SW; k++) begin
            st_in[k] = st_q[k-1];
        end
    end

    // Ready chain: stage k may load unless it and every stage after it is full and downstream is stalled.
    always_comb begin
        logic all_full;
        all_full  = 1'b1;
        stage_rdy = '0;
        for (int k = SW - 1; k >= 0; k--) begin
            all_full     = all_full & st_q[k].vld;
            stage_rdy[k] = bus.down_ready | ~all_full;
        end
    end

    assign bus.up_ready = stage_rdy[0];

    // Per-stage shift by 2**k when shamt bit k is set; overflow if the bits shifted out plus the new
    // sign bit (top 2**k+1 bits) were not all copies of the sign.
    always_comb begin
        logic [N-1:0] top;
        top = '0;
        for (int k = 0; k < SW; k++) begin
            st_d[k] = st_q[k];
            if (stage_rdy[k]) begin
                st_d[k] = st_in[k];
                if (st_in[k].shamt[k]) begin
                    top          = $signed(st_in[k].data) >>> (N - 1 - (1 << k));
                    st_d[k].data = st_in[k].data << (1 << k);
                    st_d[k].ovf  = st_in[k].ovf | ~((top == '0) | (top == '1));
                end
            end
        end
    end

    // Stage registers; reset empties the pipe and clears every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SW; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign bus.down_valid = st_q[SW-1].vld;
    assign bus.down_ovf   = st_q[SW-1].ovf;

`ifdef ARITH_LSHIFT_SATURATE_EN
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    // Clamp toward the sign of the original operand whenever the product did not fit.
    always_comb begin
        bus.down_data = st_q[SW-1].data;
        if (st_q[SW-1].ovf) begin
            bus.down_data = st_q[SW-1].sign ? MIN_NEG : MAX_POS;
        end
    end
`else
    assign bus.down_data = st_q[SW-1].data;
`endif

endmodule

// File: tb/tb_arithmetic_left_shift_pipelined_with_overflow.sv
module tb_arithmetic_left_shift_pipelined_with_overflow;
    localparam int N    = 8;
    localparam int NDIR = 12;

    localparam logic [7:0] DIR_A   [NDIR] = '{8'd5, 8'hFD, 8'd20, 8'h80, 8'hC0, 8'd7,
                                               8'hFF, 8'd0, 8'd1, 8'd127, 8'hBF, 8'd3};
    localparam logic [2:0] DIR_S   [NDIR] = '{3'd3, 3'd2, 3'd3, 3'd1, 3'd1, 3'd0,
                                               3'd7, 3'd7, 3'd7, 3'd1, 3'd1, 3'd5};
    localparam logic       DIR_OVF [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef ARITH_LSHIFT_SATURATE_EN
    localparam logic [7:0] DIR_EXP [NDIR] = '{8'h28, 8'hF4, 8'h7F, 8'h80, 8'h80, 8'h07,
                                               8'h80, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'h60};
`else
    localparam logic [7:0] DIR_EXP [NDIR] = '{8'h28, 8'hF4, 8'hA0, 8'h00, 8'h80, 8'h07,
                                               8'h80, 8'h00, 8'h80, 8'hFE, 8'h7E, 8'h60};
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    arithmetic_left_shift_pipelined_with_overflow_if #(.N(N)) bus ();

    arithmetic_left_shift_pipelined_with_overflow #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: exact product with wide integers, then range check and truncate/clamp.
    function automatic void model(input logic [7:0] a, input logic [2:0] s,
                                  output logic [7:0] d, output logic o);
        longint p;
        p = longint'($signed(a)) * (longint'(1) << s);
        o = (p < -128) || (p > 127);
        d = p[7:0];
`ifdef ARITH_LSHIFT_SATURATE_EN
        if (o) d = (p < 0) ? 8'h80 : 8'h7F;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.up_valid = 1'b0; bus.up_data = '0; bus.up_shamt = '0; bus.down_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.down_valid !== 1'b0) begin bad++; $display("FAIL rst_dvalid: got %b want 0", bus.down_valid); end
        total++; if (bus.down_data !== 8'h00) begin bad++; $display("FAIL rst_ddata: got %h want 00", bus.down_data); end
        total++; if (bus.down_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", bus.down_ovf); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.up_ready !== 1'b1) begin bad++; $display("FAIL rst_uready: got %b want 1", bus.up_ready); end
        total++; if (bus.down_valid !== 1'b0) begin bad++; $display("FAIL post_rst_dvalid: got %b want 0", bus.down_valid); end
    endtask

    task automatic test_directed();
        int cyc;
        bus.down_ready = 1'b1;
        for (int i = 0; i < NDIR; i++) begin
            bus.up_valid = 1'b1; bus.up_data = DIR_A[i]; bus.up_shamt = DIR_S[i];
            @(posedge clk); #1;
            bus.up_valid = 1'b0;
            cyc = 1;
            while (!bus.down_valid && cyc < 10) begin
                @(posedge clk); #1;
                cyc++;
            end
            total++; if (cyc !== 3) begin bad++; $display("FAIL dir_latency[%0d]: got %0d want 3", i, cyc); end
            total++; if (bus.down_data !== DIR_EXP[i]) begin bad++; $display("FAIL dir_data[%0d]: got %h want %h", i, bus.down_data, DIR_EXP[i]); end
            total++; if (bus.down_ovf !== DIR_OVF[i]) begin bad++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, bus.down_ovf, DIR_OVF[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [$];
        logic       exp_o [$];
        logic [7:0] ed;
        logic       eo;
        int idx = 0;
        int got = 0;
        bus.down_ready = 1'b0;
        for (int c = 0; c < 200 && got < 6; c++) begin
            if (c == 5) bus.down_ready = 1'b1;
            bus.up_valid = (idx < 6);
            if (idx < 6 && (c == 0 || bus.up_ready)) begin
                bus.up_data  = 8'($urandom);
                bus.up_shamt = 3'($urandom_range(0, 7));
            end
            #1;
            if (c == 4) begin
                total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
                total++; if (bus.up_ready !== 1'b0) begin bad++; $display("FAIL b2b_uready: got %b want 0", bus.up_ready); end
                total++; if (bus.down_valid !== 1'b1) begin bad++; $display("FAIL b2b_full: got %b want 1", bus.down_valid); end
            end
            if (bus.down_valid && bus.down_ready) begin
                total++;
                if (exp_d.size() == 0) begin
                    bad++; $display("FAIL b2b_spurious: got %h want none", bus.down_data);
                end else begin
                    ed = exp_d.pop_front(); eo = exp_o.pop_front();
                    if (bus.down_data !== ed || bus.down_ovf !== eo) begin
                        bad++; $display("FAIL b2b_item[%0d]: got %h/%b want %h/%b", got, bus.down_data, bus.down_ovf, ed, eo);
                    end
                end
                got++;
            end
            if (bus.up_valid && bus.up_ready) begin
                model(bus.up_data, bus.up_shamt, ed, eo);
                exp_d.push_back(ed); exp_o.push_back(eo);
                idx++;
            end
            @(posedge clk); #1;
        end
        bus.up_valid = 1'b0;
        total++; if (got !== 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", got); end
    endtask

    task automatic test_random();
        logic [7:0] exp_d [$];
        logic       exp_o [$];
        logic [7:0] ed;
        logic       eo;
        logic       hold = 1'b0;
        int sent = 0;
        int rcvd = 0;
        for (int c = 0; c < 20000 && rcvd < 2000; c++) begin
            if (!hold) begin
                bus.up_valid = (sent < 2000) && ($urandom_range(0, 9) < 7);
                bus.up_data  = 8'($urandom);
                bus.up_shamt = 3'($urandom_range(0, 7));
            end
            bus.down_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (bus.down_valid && bus.down_ready) begin
                total++;
                if (exp_d.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious: got %h want none", bus.down_data);
                end else begin
                    ed = exp_d.pop_front(); eo = exp_o.pop_front();
                    if (bus.down_data !== ed || bus.down_ovf !== eo) begin
                        bad++; $display("FAIL rnd_item[%0d]: got %h/%b want %h/%b", rcvd, bus.down_data, bus.down_ovf, ed, eo);
                    end
                end
                rcvd++;
            end
            hold = bus.up_valid && !bus.up_ready;
            if (bus.up_valid && bus.up_ready) begin
                model(bus.up_data, bus.up_shamt, ed, eo);
                exp_d.push_back(ed); exp_o.push_back(eo);
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.up_valid = 1'b0;
        total++; if (rcvd !== 2000) begin bad++; $display("FAIL rnd_count: got %0d want 2000", rcvd); end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        bus.down_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.up_valid = 1'b1;
            bus.up_data  = (i == 0) ? 8'd20 : 8'd5;
            bus.up_shamt = 3'd3;
            @(posedge clk); #1;
        end
        bus.up_valid = 1'b0;
        total++; if (bus.down_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight: got %b want 1", bus.down_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.down_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_dvalid: got %b want 0", bus.down_valid); end
        total++; if (bus.down_data !== 8'h00) begin bad++; $display("FAIL mid_rst_ddata: got %h want 00", bus.down_data); end
        total++; if (bus.down_ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", bus.down_ovf); end
        @(negedge clk) rst_n = 1'b1;
        bus.down_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.down_valid) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale: got %0d want 0", stale); end
        total++; if (bus.up_ready !== 1'b1) begin bad++; $display("FAIL mid_uready: got %b want 1", bus.up_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
